// File: rtl/btn_debounce_op.sv
// rtl/btn_debounce_op.sv - two-button synchronizer + debounce FSMs feeding ALU op select
// Optional auto-repeat on press pulses when BTN_REPEAT_EN is defined.
module btn_debounce_op #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_CYCLES   = 6250000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn1_raw,
  input  logic       btn2_raw,
  output logic       btn1_db,
  output logic       btn2_db,
  output logic       press1,
  output logic       press2,
  output logic [1:0] op,
  output logic       op_chg
);

  localparam int MAXC = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE} state_t;

  // Index 0 is button 1, index 1 is button 2.
  logic [1:0]    raw, sync1, sync2;
  state_t        state    [2];
  state_t        state_nx [2];
  logic [CW-1:0] cnt      [2];
  logic [CW-1:0] cnt_nx   [2];
  logic [1:0]    db, db_nx, press, press_nx;
  logic [1:0]    op_nx;
`ifdef BTN_REPEAT_EN
  localparam logic [CW-1:0] RPT_LAST = CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rpt    [2];
  logic [CW-1:0] rpt_nx [2];
`endif

  assign raw = {btn2_raw, btn1_raw};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1  <= 2'b11;
      sync2  <= 2'b11;
      db     <= 2'b11;
      press  <= 2'b00;
      op     <= 2'b11;
      op_chg <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        state[i] <= RELEASED;
        cnt[i]   <= '0;
`ifdef BTN_REPEAT_EN
        rpt[i]   <= '0;
`endif
      end
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      db     <= db_nx;
      press  <= press_nx;
      op     <= op_nx;
      op_chg <= (op_nx != op);
      for (int i = 0; i < 2; i++) begin
        state[i] <= state_nx[i];
        cnt[i]   <= cnt_nx[i];
`ifdef BTN_REPEAT_EN
        rpt[i]   <= rpt_nx[i];
`endif
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_nx[i] = state[i];
      cnt_nx[i]   = cnt[i];
      db_nx[i]    = db[i];
      press_nx[i] = 1'b0;
`ifdef BTN_REPEAT_EN
      rpt_nx[i]   = '0;
`endif
      case (state[i])
        RELEASED: begin
          if (!sync2[i]) begin
            state_nx[i] = WAIT_PRESS;
            cnt_nx[i]   = CW'(1);
          end
        end
        WAIT_PRESS: begin
          if (sync2[i]) begin
            state_nx[i] = RELEASED;
            cnt_nx[i]   = '0;
          end else if (cnt[i] >= DB_LAST) begin
            state_nx[i] = PRESSED;
            cnt_nx[i]   = '0;
            db_nx[i]    = 1'b0;
            press_nx[i] = 1'b1;
          end else begin
            cnt_nx[i] = cnt[i] + CW'(1);
          end
        end
        PRESSED: begin
          if (sync2[i]) begin
            state_nx[i] = WAIT_RELEASE;
            cnt_nx[i]   = CW'(1);
          end else begin
`ifdef BTN_REPEAT_EN
            // Repeat counter only advances while held; any other state clears it.
            if (rpt[i] >= RPT_LAST) begin
              press_nx[i] = 1'b1;
              rpt_nx[i]   = '0;
            end else begin
              rpt_nx[i] = rpt[i] + CW'(1);
            end
`endif
          end
        end
        WAIT_RELEASE: begin
          if (!sync2[i]) begin
            state_nx[i] = PRESSED;
            cnt_nx[i]   = '0;
          end else if (cnt[i] >= DB_LAST) begin
            state_nx[i] = RELEASED;
            cnt_nx[i]   = '0;
            db_nx[i]    = 1'b1;
          end else begin
            cnt_nx[i] = cnt[i] + CW'(1);
          end
        end
        default: begin
          state_nx[i] = RELEASED;
          cnt_nx[i]   = '0;
        end
      endcase
    end
    op_nx = {db_nx[0], db_nx[1]};
  end

  assign btn1_db = db[0];
  assign btn2_db = db[1];
  assign press1  = press[0];
  assign press2  = press[1];

endmodule

// File: tb/tb_btn_debounce_op.sv
// tb/tb_btn_debounce_op.sv - scoreboard bench for btn_debounce_op with DEBOUNCE_CYCLES=4
module tb_btn_debounce_op;

  logic       clk = 1'b0;
  logic       rst_n, btn1_raw, btn2_raw;
  logic       btn1_db, btn2_db, press1, press2, op_chg;
  logic [1:0] op;
  int         cyc = 0;
  int         total = 0;
  int         bad = 0;

  typedef struct {
    int         at;
    logic       p1;
    logic       p2;
    logic [1:0] op;
    logic       chg;
  } ev_t;

  ev_t exp_q[$];
  ev_t ev;

  btn_debounce_op #(.DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .btn1_raw(btn1_raw), .btn2_raw(btn2_raw),
    .btn1_db(btn1_db), .btn2_db(btn2_db), .press1(press1), .press2(press2),
    .op(op), .op_chg(op_chg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // A raw step applied now is sampled at edge cyc+1 and accepted at edge cyc+6.
  task automatic expect_ev(input int at, input logic p1, input logic p2,
                           input logic [1:0] o, input logic chg);
    ev_t e;
    e.at = at; e.p1 = p1; e.p2 = p2; e.op = o; e.chg = chg;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (press1 || press2 || op_chg) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d p1=%b p2=%b op=%b chg=%b required no pulse",
                 cyc, press1, press2, op, op_chg);
      end else begin
        ev = exp_q.pop_front();
        if (ev.at != cyc || ev.p1 !== press1 || ev.p2 !== press2 ||
            ev.op !== op || ev.chg !== op_chg) begin
          bad++;
          $display("FAIL event got cyc=%0d p1=%b p2=%b op=%b chg=%b required cyc=%0d p1=%b p2=%b op=%b chg=%b",
                   cyc, press1, press2, op, op_chg, ev.at, ev.p1, ev.p2, ev.op, ev.chg);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; btn1_raw = 1'b0; btn2_raw = 1'b1;
    tick(3);
    chk("rst_db1", btn1_db, 1'b1);
    chk("rst_db2", btn2_db, 1'b1);
    chk("rst_op", op, 2'b11);
    chk("rst_press", {press1, press2}, 2'b00);
    chk("rst_op_chg", op_chg, 1'b0);

    // Reset released with button 1 already held low.
    rst_n = 1'b1;
    expect_ev(cyc + 6, 1'b1, 1'b0, 2'b01, 1'b1);
    tick(8);
    btn1_raw = 1'b1;
    expect_ev(cyc + 6, 1'b0, 1'b0, 2'b11, 1'b1);
    tick(8);
    chk("release_db1", btn1_db, 1'b1);

    // Clean press.
    btn1_raw = 1'b0;
    expect_ev(cyc + 6, 1'b1, 1'b0, 2'b01, 1'b1);
    tick(5);
    chk("clean_db1_early", btn1_db, 1'b1);
    tick(1);
    chk("clean_db1", btn1_db, 1'b0);
    chk("clean_op", op, 2'b01);
    tick(2);
    btn1_raw = 1'b1;
    expect_ev(cyc + 6, 1'b0, 1'b0, 2'b11, 1'b1);
    tick(8);

    // Bounce: count restarts from the last stable edge.
    btn1_raw = 1'b0; tick(1);
    btn1_raw = 1'b1; tick(1);
    btn1_raw = 1'b0; tick(1);
    btn1_raw = 1'b1; tick(1);
    btn1_raw = 1'b0;
    expect_ev(cyc + 6, 1'b1, 1'b0, 2'b01, 1'b1);
    tick(5);
    chk("bounce_db1_early", btn1_db, 1'b1);
    tick(1);
    chk("bounce_db1", btn1_db, 1'b0);
    tick(2);
    btn1_raw = 1'b1;
    expect_ev(cyc + 6, 1'b0, 1'b0, 2'b11, 1'b1);
    tick(8);

    // Simultaneous press and release: single op_chg each time.
    btn1_raw = 1'b0; btn2_raw = 1'b0;
    expect_ev(cyc + 6, 1'b1, 1'b1, 2'b00, 1'b1);
    tick(8);
    chk("simul_op", op, 2'b00);
    btn1_raw = 1'b1; btn2_raw = 1'b1;
    expect_ev(cyc + 6, 1'b0, 1'b0, 2'b11, 1'b1);
    tick(8);

    // Two-cycle release glitch is rejected; a long release is accepted.
    btn2_raw = 1'b0;
    expect_ev(cyc + 6, 1'b0, 1'b1, 2'b10, 1'b1);
    tick(6);
    btn2_raw = 1'b1; tick(2);
    btn2_raw = 1'b0; tick(4);
    chk("glitch_db2", btn2_db, 1'b0);
    chk("glitch_op", op, 2'b10);
    btn2_raw = 1'b1;
    expect_ev(cyc + 6, 1'b0, 1'b0, 2'b11, 1'b1);
    tick(8);
    chk("long_release_db2", btn2_db, 1'b1);
    chk("long_release_op", op, 2'b11);

    // Reset in the middle of a debounce count discards it.
    btn1_raw = 1'b0; tick(3);
    rst_n = 1'b0; btn1_raw = 1'b1; tick(2);
    rst_n = 1'b1; tick(8);
    chk("midcount_rst_db1", btn1_db, 1'b1);

`ifdef BTN_REPEAT_EN
    // Held button repeats every 8 cycles; reset stops repeats at once.
    btn2_raw = 1'b0;
    expect_ev(cyc + 6,  1'b0, 1'b1, 2'b10, 1'b1);
    expect_ev(cyc + 14, 1'b0, 1'b1, 2'b10, 1'b0);
    expect_ev(cyc + 22, 1'b0, 1'b1, 2'b10, 1'b0);
    expect_ev(cyc + 30, 1'b0, 1'b1, 2'b10, 1'b0);
    tick(34);
    rst_n = 1'b0; tick(1);
    chk("rpt_rst_press2", press2, 1'b0);
    chk("rpt_rst_db2", btn2_db, 1'b1);
    btn2_raw = 1'b1; tick(2);
    rst_n = 1'b1; tick(20);
`endif

    tick(5);
    chk("pending_events", exp_q.size(), 0);
    while (exp_q.size() > 0) begin
      ev = exp_q.pop_front();
      $display("FAIL missing_event required cyc=%0d p1=%b p2=%b op=%b chg=%b",
               ev.at, ev.p1, ev.p2, ev.op, ev.chg);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_debounce_op.md
Name: btn_debounce_op

Overview:
- Upstream input stage for the board ALU: conditions the two raw, active-low push-buttons and presents clean, glitch-free operation-select levels to the ALU.
- Per button: two-flop synchronizer, then counter-based debounce FSM.
- Outputs debounced levels in the same active-low polarity as the raw pins, plus press pulses and an encoded op code with a change strobe.
- The ALU consumes btn1_db/btn2_db (or op) in place of the raw pins.

Parameters:
- DEBOUNCE_CYCLES, 250000, consecutive stable synchronized cycles required to accept a new level (10 ms at 25 MHz); legal range 2 to 2^24-1.
- REPEAT_CYCLES, 6250000, hold period between auto-repeat pulses; used only when BTN_REPEAT_EN is defined.
- Internal counter width is $clog2(max(DEBOUNCE_CYCLES, REPEAT_CYCLES)+1) (localparam, not overridable).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous reset, active-low, sampled on rising clk
- btn1_raw  in  1  raw button 1, active-low, asynchronous to clk
- btn2_raw  in  1  raw button 2, active-low, asynchronous to clk
- btn1_db  out  1  debounced button 1, active-low
- btn2_db  out  1  debounced button 2, active-low
- press1  out  1  one-cycle pulse on accepted press (1->0) of button 1
- press2  out  1  one-cycle pulse on accepted press of button 2
- op  out  2  {btn1_db, btn2_db}: 00 add, 01 sub, 10 and, 11 or
- op_chg  out  1  one-cycle pulse whenever op takes a new value

Behaviour:
- Reset (rst_n=0 at rising edge):
  - Sync flops = 1; btn*_db = 1; press* = 0; op = 2'b11; op_chg = 0; counters = 0.
  - Both FSMs go to RELEASED.
  - Reset applies mid-count and discards any partial debounce.
- Synchronizer: two flops per button. The raw value sampled at edge k appears at stage-2 output (s) at edge k+1.
- Per-button FSM states and transitions:
  - RELEASED (db=1): s=0 -> WAIT_PRESS with cnt=1.
  - WAIT_PRESS:
    - s=1 -> RELEASED, cnt=0.
    - s=0 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED; db<=0 and press<=1 on the same edge.
    - Otherwise cnt++.
  - PRESSED (db=0): s=1 -> WAIT_RELEASE with cnt=1.
  - WAIT_RELEASE:
    - s=0 -> PRESSED, cnt=0.
    - s=1 and cnt=DEBOUNCE_CYCLES-1 -> RELEASED; db<=1 on that edge, no pulse.
    - Otherwise cnt++.
- Latency: a clean raw step held from edge k updates db at edge k+1+DEBOUNCE_CYCLES. Any bounce restarts the count from the first edge at which s is stable again.
- op, op_chg, and press* are all registered. op updates on the same edge as the db change.
- op_chg is high for exactly the cycle following any edge where op changed. Both buttons accepted on the same edge give one op_chg pulse only.
- The two buttons are fully independent; simultaneous events on both are legal.
- Counters saturate at DEBOUNCE_CYCLES-1 and never wrap.
- No output is combinationally dependent on raw inputs.

Optional Feature:
- BTN_REPEAT_EN defined:
  - In PRESSED with s=0, a repeat counter runs.
  - The first repeat pulse on press* comes REPEAT_CYCLES cycles after the accepted press, then every REPEAT_CYCLES cycles while held.
  - The repeat counter clears on leaving PRESSED and on reset.
  - op and op_chg are unaffected by repeats.
- BTN_REPEAT_EN undefined: exactly one press pulse per accepted press; no repeat logic synthesized.

Test Plan:
- DEBOUNCE_CYCLES=4 for all scenarios.
- Reset: hold rst_n=0 for 3 cycles with raw=0 -> db=1, op=11, press=0, op_chg=0. Release reset -> db1 falls 5 cycles later with press1 and op_chg pulses, op=01.
- Clean press: btn1_raw 1->0 held from edge 10 -> btn1_db=0 and press1=1 at edge 15 only; op 11->01; op_chg=1 for one cycle.
- Bounce: btn1_raw toggles 0,1,0,1 on edges 10-13, then 0 held -> no db change before edge 19; a single press1 pulse at edge 19.
- Simultaneous press: both raw ->0 at edge 10 -> both db=0 at edge 15, op=00, one op_chg pulse, press1 and press2 both pulse.
- Release glitch: pressed button sees a 2-cycle high glitch -> db stays 0 and no op_chg. A release held for 4+ cycles -> db=1, op returns to 11, no press pulse.
- BTN_REPEAT_EN with REPEAT_CYCLES=8: hold btn2 for 30 cycles after acceptance -> press2 pulses at +0, +8, +16, +24. Reset mid-hold -> pulses stop immediately.
